keypad_dir_ctrl: RTL and testbench



---
 rtl/keypad_dir_ctrl.sv | 149 ++++++++++++++
 tb/tb_keypad_dir_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_dir_ctrl.sv
// Debounced N-key direction decoder with move strobe and auto-repeat.
// Path: raw keys -> 2-flop sync -> per-key debounce -> registered decode -> direction/repeat FSM.
module keypad_dir_ctrl #(
  parameter int NUM_KEYS     = 4,
  parameter int DEB_CYCLES   = 8,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8,
  parameter int DIR_W        = $clog2(NUM_KEYS + 1)
) (
  input  logic                KB_clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [DIR_W-1:0]    direction,
  output logic                move_pulse,
  output logic [NUM_KEYS-1:0] pressed,
  output logic                multi_press
);

  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RC_W    = $clog2(RPT_MAX + 1);

  localparam logic [DIR_W-1:0] STILL    = DIR_W'(NUM_KEYS);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [RC_W-1:0]  DELAY_LD = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0]  RATE_LD  = RC_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] key_s;
  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] deb;
  logic [DEB_W-1:0]    deb_cnt [NUM_KEYS];

  logic [DIR_W-1:0]    pop;
  logic [DIR_W-1:0]    code;
  logic                multi;
  logic [DIR_W-1:0]    code_q;

  state_t              state;
  state_t              state_nxt;
  logic [RC_W-1:0]     rpt_cnt;
  logic [RC_W-1:0]     rpt_nxt;
  logic                pulse_nxt;

  assign raw = ~key_s;

  // Synchroniser and debounce; deb holds the active-high debounced key state.
  always_ff @(posedge KB_clk) begin
    if (rst) begin
      sync1 <= '1;
      key_s <= '1;
      deb   <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1 <= key_n;
      key_s <= sync1;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (raw[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  always_comb begin
    pop  = '0;
    code = STILL;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (deb[i]) begin
        pop  = pop + DIR_W'(1);
        code = DIR_W'(i);
      end
    end
    if (pop != DIR_W'(1)) begin
      code = STILL;
    end
    multi = (pop >= DIR_W'(2));
  end

  // code_q is the decoded "next direction"; direction trails it by one cycle
  // so that move_pulse can be asserted in the same cycle direction changes.
  always_ff @(posedge KB_clk) begin
    if (rst) begin
      pressed     <= '0;
      multi_press <= 1'b0;
      code_q      <= STILL;
      direction   <= STILL;
      move_pulse  <= 1'b0;
      rpt_cnt     <= '0;
      state       <= IDLE;
    end else begin
      pressed     <= deb;
      multi_press <= multi;
      code_q      <= code;
      direction   <= code_q;
      move_pulse  <= pulse_nxt;
      rpt_cnt     <= rpt_nxt;
      state       <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rpt_nxt   = rpt_cnt;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if ((code_q != direction) && (code_q != STILL)) begin
          pulse_nxt = 1'b1;
          rpt_nxt   = DELAY_LD;
          state_nxt = HOLD;
        end
      end
      HOLD, REPEAT: begin
        // A change of decoded direction always overrides the repeat timer.
        if (code_q == STILL) begin
          state_nxt = IDLE;
        end else if (code_q != direction) begin
          pulse_nxt = 1'b1;
          rpt_nxt   = DELAY_LD;
          state_nxt = HOLD;
        end else if (rpt_cnt == '0) begin
          pulse_nxt = 1'b1;
          rpt_nxt   = RATE_LD;
          state_nxt = REPEAT;
        end else begin
          rpt_nxt = rpt_cnt - RC_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_dir_ctrl.sv
// Directed bench for keypad_dir_ctrl (NUM_KEYS=4, DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3).
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_keypad_dir_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] key_n;
  logic [2:0] direction;
  logic       move_pulse;
  logic [3:0] pressed;
  logic       multi_press;

  int errors;
  int checks;

  keypad_dir_ctrl #(
    .NUM_KEYS     (4),
    .DEB_CYCLES   (4),
    .REPEAT_DELAY (10),
    .REPEAT_RATE  (3)
  ) dut (
    .KB_clk      (clk),
    .rst         (rst),
    .key_n       (key_n),
    .direction   (direction),
    .move_pulse  (move_pulse),
    .pressed     (pressed),
    .multi_press (multi_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles, requiring move_pulse low after each one.
  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      chk(tag, 32'(move_pulse), 0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    key_n  = 4'b1111;

    // Reset
    tick(3);
    chk("rst_dir", 32'(direction), 4);
    chk("rst_pulse", 32'(move_pulse), 0);
    chk("rst_pressed", 32'(pressed), 0);
    chk("rst_multi", 32'(multi_press), 0);
    rst = 1'b0;
    tick(2);

    // Clean press of key 1: pressed after 7 cycles, direction+pulse after 8 samples
    key_n = 4'b1101;
    quiet("press1_quiet", 6);
    chk("press1_pressed_early", 32'(pressed), 0);
    tick(1);
    chk("press1_pressed", 32'(pressed), 4'b0010);
    chk("press1_dir_early", 32'(direction), 4);
    chk("press1_pulse_early", 32'(move_pulse), 0);
    tick(1);
    chk("press1_dir", 32'(direction), 1);
    chk("press1_pulse", 32'(move_pulse), 1);
    tick(1);
    chk("press1_pulse_end", 32'(move_pulse), 0);

    // Release before the first repeat falls due: no pulse at all
    key_n = 4'b1111;
    quiet("rel1_quiet", 6);
    chk("rel1_dir_hold", 32'(direction), 1);
    quiet("rel1_quiet2", 1);
    chk("rel1_dir_hold2", 32'(direction), 1);
    quiet("rel1_quiet3", 1);
    chk("rel1_dir", 32'(direction), 4);
    chk("rel1_pressed", 32'(pressed), 0);
    quiet("rel1_quiet4", 4);

    // Bounce: 3-cycle glitch on key 0 is rejected
    key_n = 4'b1110;
    tick(3);
    key_n = 4'b1111;
    quiet("bounce_quiet", 12);
    chk("bounce_pressed", 32'(pressed), 0);
    chk("bounce_dir", 32'(direction), 4);

    // Steady press of key 0
    key_n = 4'b1110;
    quiet("key0_quiet", 7);
    chk("key0_dir_early", 32'(direction), 4);
    tick(1);
    chk("key0_dir", 32'(direction), 0);
    chk("key0_pulse", 32'(move_pulse), 1);
    chk("key0_pressed", 32'(pressed), 4'b0001);
    key_n = 4'b1111;
    quiet("key0_rel_quiet", 12);
    chk("key0_rel_dir", 32'(direction), 4);

    // Auto-repeat on key 2: pulses at t0, t0+10, t0+13, ...; release after
    // sampling at k=40 lands direction=4 at k=48, cancelling the k=49 repeat.
    key_n = 4'b1011;
    quiet("rpt_quiet", 7);
    tick(1);
    chk("rpt_dir", 32'(direction), 2);
    chk("rpt_pulse_t0", 32'(move_pulse), 1);
    for (int k = 1; k <= 52; k++) begin
      tick(1);
      chk($sformatf("rpt_pulse_k%0d", k), 32'(move_pulse),
          (k >= 10 && ((k - 10) % 3) == 0 && k < 48) ? 1 : 0);
      chk($sformatf("rpt_dir_k%0d", k), 32'(direction), (k >= 48) ? 4 : 2);
      if (k == 40) key_n = 4'b1111;
    end

    // Chord: key 1 then key 3 -> stationary, no pulse
    key_n = 4'b1101;
    tick(8);
    chk("chord_k1_dir", 32'(direction), 1);
    chk("chord_k1_pulse", 32'(move_pulse), 1);
    key_n = 4'b0101;
    quiet("chord_quiet", 7);
    chk("chord_dir_early", 32'(direction), 1);
    chk("chord_multi_early", 32'(multi_press), 1);
    quiet("chord_quiet2", 1);
    chk("chord_dir", 32'(direction), 4);
    chk("chord_multi", 32'(multi_press), 1);
    chk("chord_pressed", 32'(pressed), 4'b1010);

    // Release key 1 -> key 3 alone, pulse and a fresh 10-cycle delay
    key_n = 4'b0111;
    quiet("switch_quiet", 7);
    tick(1);
    chk("switch_dir", 32'(direction), 3);
    chk("switch_pulse", 32'(move_pulse), 1);
    chk("switch_multi", 32'(multi_press), 0);
    chk("switch_pressed", 32'(pressed), 4'b1000);
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      chk($sformatf("switch_rpt_k%0d", k), 32'(move_pulse), (k == 10) ? 1 : 0);
    end
    key_n = 4'b1111;
    tick(20);
    chk("switch_rel_dir", 32'(direction), 4);

    // Reset in REPEAT with key 2 held, then re-detection
    key_n = 4'b1011;
    tick(8);
    chk("mrst_dir_pre", 32'(direction), 2);
    chk("mrst_pulse_pre", 32'(move_pulse), 1);
    tick(12);
    rst = 1'b1;
    tick(1);
    chk("mrst_dir", 32'(direction), 4);
    chk("mrst_pulse", 32'(move_pulse), 0);
    chk("mrst_pressed", 32'(pressed), 0);
    chk("mrst_multi", 32'(multi_press), 0);
    rst = 1'b0;
    quiet("mrst_quiet", 7);
    chk("mrst_dir_early", 32'(direction), 4);
    tick(1);
    chk("mrst_redetect_dir", 32'(direction), 2);
    chk("mrst_redetect_pulse", 32'(move_pulse), 1);
    tick(1);
    chk("mrst_pulse_end", 32'(move_pulse), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
